// File: rtl/qcpu_spi_master.sv
// SPI master with configurable word width, CPOL/CPHA mode, bit order and decoded chip selects.
// Transfers run LEAD -> SHIFT -> TAIL; every phase is counted in SCLK half-periods.
module qcpu_spi_master #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  parameter int NUM_CS = 4,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  divisor,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              hold_cs,
  input  logic [DATA_W-1:0] din,
  input  logic              start,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] CS_N
);

  localparam int EC_W = $clog2(2 * DATA_W + 1);
  localparam int IX_W = $clog2(DATA_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] TAIL  = 2'd3;

  logic [1:0]        state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic              cpol_q, cpha_q, lsb_q, hold_q;
  logic [DATA_W-1:0] tx_q, rx_q;
  logic [EC_W-1:0]   ecnt;

  logic              half_end;
  logic [EC_W-1:0]   e_num, samp_idx, drv_idx;
  logic              is_samp;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == CS_W'(i)) cs_decode[i] = 1'b0;
  endfunction

  function automatic logic [IX_W-1:0] bit_pos(input logic [EC_W-1:0] j, input logic lsb);
    bit_pos = lsb ? IX_W'(j) : (IX_W'(DATA_W - 1) - IX_W'(j));
  endfunction

  // e_num is the 1-based SCLK edge about to happen; odd edges are leading.
  // Both modes sample bit (e-1)/2 and drive bit e/2, on opposite parities.
  assign half_end = (cnt == div_q);
  assign e_num    = ecnt + EC_W'(1);
  assign samp_idx = ecnt >> 1;
  assign drv_idx  = e_num >> 1;
  assign is_samp  = e_num[0] ^ cpha_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ecnt  <= '0;
      dout  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      SCLK  <= 1'b0;
      MOSI  <= 1'b0;
      CS_N  <= '1;
    end else begin
      done <= 1'b0;
      if (state == IDLE) cnt <= '0;
      else               cnt <= half_end ? '0 : cnt + DIV_W'(1);

      case (state)
        IDLE: begin
          SCLK <= cpol;
          if (start) begin
            div_q  <= divisor;
            cpol_q <= cpol;
            cpha_q <= cpha;
            lsb_q  <= lsb_first;
            hold_q <= hold_cs;
            tx_q   <= din;
            ecnt   <= '0;
            busy   <= 1'b1;
            CS_N   <= cs_decode(cs_sel);
            state  <= LEAD;
            if (!cpha) MOSI <= lsb_first ? din[0] : din[DATA_W-1];
          end
        end
        LEAD, SHIFT: begin
          if (half_end) begin
            if (state == SHIFT && ecnt == EC_W'(2 * DATA_W)) begin
              SCLK  <= cpol_q;
              state <= TAIL;
            end else begin
              SCLK  <= ~SCLK;
              ecnt  <= e_num;
              state <= SHIFT;
              if (is_samp) rx_q[bit_pos(samp_idx, lsb_q)] <= MISO;
              else if (drv_idx < EC_W'(DATA_W)) MOSI <= tx_q[bit_pos(drv_idx, lsb_q)];
            end
          end
        end
        TAIL: begin
          if (half_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dout  <= rx_q;
            MOSI  <= 1'b0;
            if (!hold_q) CS_N <= '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qcpu_spi_master.sv
// Bench for qcpu_spi_master: directed cases plus randomized transfers against a
// behavioural SPI slave/observer that works purely from observed SCLK edges.
module tb_qcpu_spi_master;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
  localparam int NUM_CS = 3;
  localparam int CS_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  divisor;
  logic              cpol, cpha, lsb_first, hold_cs, start, MISO;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] din, dout;
  logic              busy, done, SCLK, MOSI;
  logic [NUM_CS-1:0] CS_N;

  int checks = 0;
  int errors = 0;

  qcpu_spi_master #(.DATA_W(DATA_W), .DIV_W(DIV_W), .NUM_CS(NUM_CS)) dut (
    .clk(clk), .rst(rst), .divisor(divisor), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cs_sel(cs_sel), .hold_cs(hold_cs), .din(din),
    .start(start), .dout(dout), .busy(busy), .done(done), .SCLK(SCLK),
    .MOSI(MOSI), .MISO(MISO), .CS_N(CS_N)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position in the word of the i-th bit on the wire.
  function automatic int wpos(input int i, input logic lsb);
    return lsb ? i : DATA_W - 1 - i;
  endfunction

  function automatic logic [NUM_CS-1:0] cs_exp(input int sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    if (sel < NUM_CS) v[sel] = 1'b0;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transfer. sw = word the slave returns; loopback ties MISO to MOSI.
  // rst_edge > 0 aborts with a reset once that many SCLK edges were seen.
  task automatic xfer(input string name, input int div, input logic c_pol, input logic c_pha,
                      input logic lsb, input int sel, input logic hold,
                      input logic [7:0] d, input logic [7:0] sw, input logic loopback,
                      input int rst_edge, input logic mid_start);
    int exp_cycles, busy_cnt, edges, done_cnt, samp_n, idx;
    logic prev_sclk, cs_bad, finished;
    logic [7:0] mosi_word;
    exp_cycles = (2 * DATA_W + 2) * (div + 1);
    busy_cnt = 0; edges = 0; done_cnt = 0; samp_n = 0;
    cs_bad = 1'b0; finished = 1'b0; mosi_word = '0;

    divisor = DIV_W'(div); cpol = c_pol; cpha = c_pha; lsb_first = lsb;
    cs_sel = CS_W'(sel); hold_cs = hold; din = d;
    MISO = loopback ? 1'b0 : sw[wpos(0, lsb)];
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    prev_sclk = c_pol;

    for (int cyc = 0; cyc < exp_cycles + 20; cyc++) begin
      if (busy) begin
        busy_cnt++;
        if (CS_N !== cs_exp(sel)) cs_bad = 1'b1;
      end
      if (busy && SCLK !== prev_sclk) begin
        edges++;
        if ((edges % 2 == 1) != c_pha) begin
          if (samp_n < DATA_W) mosi_word[wpos(samp_n, lsb)] = MOSI;
          samp_n++;
        end
      end
      prev_sclk = SCLK;
      if (done) done_cnt++;
      // Slave presents its next bit after its shift edge (trailing for cpha=0, leading for 1).
      idx = c_pha ? ((edges + 1) / 2 - 1) : (edges / 2);
      if (idx < 0) idx = 0;
      if (idx > DATA_W - 1) idx = DATA_W - 1;
      MISO = loopback ? MOSI : sw[wpos(idx, lsb)];

      if (mid_start && cyc == 3) begin
        start = 1'b1; din = ~d; cs_sel = CS_W'(sel + 1); divisor = DIV_W'(div + 2);
        lsb_first = ~lsb; cpha = ~c_pha; hold_cs = ~hold;
      end
      if (mid_start && cyc == 4) begin
        start = 1'b0; din = d; cs_sel = CS_W'(sel); divisor = DIV_W'(div);
        lsb_first = lsb; cpha = c_pha; hold_cs = hold;
      end

      if (rst_edge > 0 && edges == rst_edge) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({name, "_rst_csn"}, CS_N, {NUM_CS{1'b1}});
        chk({name, "_rst_busy"}, busy, 1'b0);
        chk({name, "_rst_sclk"}, SCLK, 1'b0);
        chk({name, "_rst_done"}, done, 1'b0);
        chk({name, "_rst_dout"}, dout, 8'h00);
        for (int k = 0; k < 3; k++) begin
          tick();
          chk({name, "_rst_nodone"}, {busy, done}, 2'b00);
        end
        return;
      end

      if (!busy && busy_cnt > 0) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    tick();
    if (done) done_cnt++;

    chk({name, "_finished"}, finished, 1'b1);
    chk({name, "_busy_cycles"}, busy_cnt, exp_cycles);
    chk({name, "_sclk_edges"}, edges, 2 * DATA_W);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_dout"}, dout, loopback ? d : sw);
    chk({name, "_mosi_word"}, mosi_word, d);
    chk({name, "_cs_during"}, cs_bad, 1'b0);
    chk({name, "_cs_after"}, CS_N, hold ? cs_exp(sel) : {NUM_CS{1'b1}});
    chk({name, "_sclk_idle"}, SCLK, c_pol);
    chk({name, "_mosi_idle"}, MOSI, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; divisor = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    cs_sel = '0; hold_cs = 1'b0; din = '0; MISO = 1'b0;
    repeat (3) tick();
    chk("reset_dout", dout, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sclk", SCLK, 1'b0);
    chk("reset_mosi", MOSI, 1'b0);
    chk("reset_csn", CS_N, {NUM_CS{1'b1}});
    rst = 1'b0;
    tick();

    xfer("mode0_loop", 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'hA5, 8'h00, 1'b1, 0, 1'b0);
    xfer("mode3_div3", 3, 1'b1, 1'b1, 1'b0, 1, 1'b0, 8'h3C, 8'hC3, 1'b0, 0, 1'b0);
    xfer("lsb_first", 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h01, 8'h80, 1'b0, 0, 1'b0);
    xfer("hold_1", 1, 1'b0, 1'b1, 1'b0, 2, 1'b1, 8'h5A, 8'h96, 1'b0, 0, 1'b1);
    xfer("hold_2", 0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 8'hE7, 8'h18, 1'b0, 0, 1'b0);
    xfer("hold_sw_a", 0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 8'h0F, 8'hF0, 1'b0, 0, 1'b0);
    xfer("hold_sw_b", 0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 8'hC9, 8'h36, 1'b0, 0, 1'b0);
    xfer("rst_mid", 1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h77, 8'h99, 1'b0, 7, 1'b0);
    xfer("after_rst", 0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h6B, 8'hD2, 1'b0, 0, 1'b0);
    xfer("cs_out_range", 0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8'h42, 8'h24, 1'b0, 0, 1'b0);
    xfer("div_max", 255, 1'b0, 1'b1, 1'b1, 0, 1'b0, 8'h81, 8'h7E, 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      xfer("rand", int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 3) == 0), 0, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
